// File: rtl/shift_sequencer.sv
// Multi-cycle shifter: breaks an 8-bit shift count into steps of at most MAX_STEP.
// Optional macro FAST_PATH_EN normalises the remaining count at accept time.
module shift_sequencer #(
    parameter int MAX_STEP = 7
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_start,
    input  logic [1:0] i_opcode,
    input  logic [7:0] i_data1,
    input  logic [7:0] i_amount,
    output logic       o_busy,
    output logic       o_done,
    output logic [7:0] o_result,
    output logic       o_zero
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_work;
    logic [1:0]  r_op;
    logic [7:0]  r_rem;
    logic [7:0]  r_result;
    logic        r_zero;

    logic        w_accept;
    logic [2:0]  w_step;
    logic [7:0]  w_rem_next;
    logic [7:0]  w_rem_init;
    logic [7:0]  w_work_next;
    logic [15:0] w_rot;

    assign w_accept = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));

    always_comb begin
        w_step = r_rem[2:0];
        if (r_rem > 8'(MAX_STEP)) begin
            w_step = 3'(MAX_STEP);
        end
    end

    assign w_rem_next = r_rem - {5'd0, w_step};
    assign w_rot      = {r_work, r_work} >> w_step;

    always_comb begin
        w_work_next = w_rot[7:0];
        case (r_op)
            OP_SLL:  w_work_next = r_work << w_step;
            OP_SRL:  w_work_next = r_work >> w_step;
            OP_SRA:  w_work_next = $signed(r_work) >>> w_step;
            default: w_work_next = w_rot[7:0];
        endcase
    end

`ifdef FAST_PATH_EN
    // Rotation repeats every 8; linear shifts saturate after 8, so 8 suffices.
    always_comb begin
        w_rem_init = i_amount;
        if (i_opcode == 2'b11) begin
            w_rem_init = {5'd0, i_amount[2:0]};
        end else if (i_amount > 8'd8) begin
            w_rem_init = 8'd8;
        end
    end
`else
    assign w_rem_init = i_amount;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_SHIFT;
            S_SHIFT: if (w_rem_next == 8'd0) w_next = S_DONE;
            S_DONE:  w_next = w_accept ? S_SHIFT : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state  <= S_IDLE;
            r_work   <= 8'h00;
            r_op     <= 2'b00;
            r_rem    <= 8'h00;
            r_result <= 8'h00;
            r_zero   <= 1'b1;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_work <= i_data1;
                r_op   <= i_opcode;
                r_rem  <= w_rem_init;
            end else if (r_state == S_SHIFT) begin
                r_work <= w_work_next;
                r_rem  <= w_rem_next;
                if (w_rem_next == 8'd0) begin
                    r_result <= w_work_next;
                    r_zero   <= (w_work_next == 8'h00);
                end
            end
        end
    end

    assign o_busy   = (r_state == S_SHIFT);
    assign o_done   = (r_state == S_DONE);
    assign o_result = r_result;
    assign o_zero   = r_zero;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: directed plan items plus random ops against an arithmetic model.
module tb_shift_sequencer;

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b0;
    logic       i_start = 1'b0;
    logic [1:0] i_opcode = 2'b00;
    logic [7:0] i_data1 = 8'h00;
    logic [7:0] i_amount = 8'h00;
    logic       o_busy;
    logic       o_done;
    logic [7:0] o_result;
    logic       o_zero;

    int total = 0;
    int bad = 0;
    logic [7:0] model_result = 8'h00;

    shift_sequencer #(.MAX_STEP(7)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start),
        .i_opcode(i_opcode), .i_data1(i_data1), .i_amount(i_amount),
        .o_busy(o_busy), .o_done(o_done), .o_result(o_result), .o_zero(o_zero)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [7:0] ref_result(input logic [1:0] op, input logic [7:0] d, input logic [7:0] a);
        int v;
        int r;
        case (op)
            2'b00: v = (a >= 8) ? 0 : ((int'(d) * (1 << a)) % 256);
            2'b01: v = (a >= 8) ? 0 : (int'(d) / (1 << a));
            2'b10: begin
                v = d[7] ? int'(d) - 256 : int'(d);
                if (a >= 8) v = d[7] ? 255 : 0;
                else begin
                    for (int k = 0; k < int'(a); k++) v = (v < 0) ? (v - 1) / 2 : v / 2;
                    v = (v + 256) % 256;
                end
            end
            default: begin
                r = int'(a) % 8;
                v = ((int'(d) / (1 << r)) + (int'(d) * (1 << (8 - r)))) % 256;
            end
        endcase
        return 8'(v);
    endfunction

    function automatic int ref_latency(input logic [1:0] op, input logic [7:0] a);
`ifdef FAST_PATH_EN
        if (op == 2'b11) return 1;
        return (a >= 8) ? 2 : 1;
`else
        if (a == 0) return 1;
        return (int'(a) + 6) / 7;
`endif
    endfunction

    // Drives one request (accepted at the next edge) and waits for DONE; returns observations.
    task automatic launch(input logic [1:0] op, input logic [7:0] d, input logic [7:0] a,
                          input bit poke, output int n, output bit held_ok, output bit excl_ok);
        i_start = 1'b1; i_opcode = op; i_data1 = d; i_amount = a;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        n = 0; held_ok = 1'b1; excl_ok = 1'b1;
        while (n < 300) begin
            if (!(o_busy && !o_done)) excl_ok = 1'b0;
            if (o_result !== model_result) held_ok = 1'b0;
            if (poke && ($urandom_range(2) == 0)) begin
                i_start = 1'b1; i_opcode = 2'($urandom); i_data1 = 8'($urandom); i_amount = 8'($urandom);
            end
            @(posedge i_clk); #1;
            i_start = 1'b0;
            n++;
            if (o_done) break;
        end
        if (o_busy) excl_ok = 1'b0;
    endtask

    task automatic check_op(input string nm, input logic [1:0] op, input logic [7:0] d,
                            input logic [7:0] a, input bit poke);
        int n;
        bit held_ok, excl_ok;
        logic [7:0] er;
        er = ref_result(op, d, a);
        launch(op, d, a, poke, n, held_ok, excl_ok);
        total++;
        if (o_done !== 1'b1) begin
            bad++; $display("FAIL %s done: got %b want 1 (timeout)", nm, o_done);
        end
        total++;
        if (n != ref_latency(op, a)) begin
            bad++; $display("FAIL %s latency: got %0d want %0d", nm, n, ref_latency(op, a));
        end
        total++;
        if (o_result !== er || o_zero !== (er == 8'h00)) begin
            bad++; $display("FAIL %s result: got %h/z%b want %h/z%b", nm, o_result, o_zero, er, er == 8'h00);
        end
        total++;
        if (!held_ok || !excl_ok) begin
            bad++; $display("FAIL %s busy/hold: got held=%b excl=%b want 1/1", nm, held_ok, excl_ok);
        end
        model_result = er;
    endtask

    task automatic check_idle_after(input string nm);
        @(posedge i_clk); #1;
        total++;
        if (o_done !== 1'b0 || o_busy !== 1'b0 || o_result !== model_result) begin
            bad++; $display("FAIL %s idle: got d%b b%b r%h want d0 b0 r%h", nm, o_done, o_busy, o_result, model_result);
        end
    endtask

    task automatic test_reset();
        bit saw_done;
        repeat (2) @(posedge i_clk);
        #1;
        total++;
        if (o_busy !== 1'b0 || o_done !== 1'b0 || o_result !== 8'h00 || o_zero !== 1'b1) begin
            bad++; $display("FAIL reset_init: got b%b d%b r%h z%b want b0 d0 r00 z1", o_busy, o_done, o_result, o_zero);
        end
        i_reset = 1'b1;
        check_op("pre_abort", 2'b00, 8'h01, 8'd3, 1'b0);
        i_start = 1'b1; i_opcode = 2'b01; i_data1 = 8'hFF; i_amount = 8'd200;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        repeat (5) @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        i_reset = 1'b1;
        model_result = 8'h00;
        total++;
        if (o_busy !== 1'b0 || o_done !== 1'b0 || o_result !== 8'h00 || o_zero !== 1'b1) begin
            bad++; $display("FAIL reset_abort: got b%b d%b r%h z%b want b0 d0 r00 z1", o_busy, o_done, o_result, o_zero);
        end
        saw_done = 1'b0;
        repeat (40) begin
            @(posedge i_clk); #1;
            if (o_done || o_busy) saw_done = 1'b1;
        end
        total++;
        if (saw_done) begin
            bad++; $display("FAIL reset_no_done: got activity=1 want 0");
        end
    endtask

    task automatic test_sll();
        check_op("sll_1_3", 2'b00, 8'h01, 8'd3, 1'b0);
        check_idle_after("sll_1_3");
        check_op("sll_amt0", 2'b00, 8'h5A, 8'd0, 1'b0);
        check_idle_after("sll_amt0");
    endtask

    task automatic test_sra();
        check_op("sra_80_20", 2'b10, 8'h80, 8'd20, 1'b0);
        check_idle_after("sra_80_20");
    endtask

    task automatic test_ror();
        check_op("ror_81_9", 2'b11, 8'h81, 8'd9, 1'b0);
        check_idle_after("ror_81_9");
    endtask

    task automatic test_srl_long();
        check_op("srl_ff_255", 2'b01, 8'hFF, 8'd255, 1'b1);
        check_idle_after("srl_ff_255");
    endtask

    task automatic test_back_to_back();
        check_op("b2b_first", 2'b10, 8'hC4, 8'd10, 1'b0);
        check_op("b2b_second", 2'b00, 8'h03, 8'd1, 1'b0);
        check_idle_after("b2b_second");
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            logic [7:0] a;
            a = ($urandom_range(3) == 0) ? 8'($urandom) : 8'($urandom_range(20));
            check_op("rand", 2'($urandom), 8'($urandom), a, bit'($urandom_range(1)));
            if ($urandom_range(1) == 0) check_idle_after("rand");
        end
        check_idle_after("rand_end");
    endtask

    initial begin
        test_reset();
        test_sll();
        test_sra();
        test_ror();
        test_srl_long();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
Multi-cycle shift unit that sits directly upstream of the ALU's 3-bit barrel shifters and extends them to full 8-bit shift amounts, which come from an 8-bit immediate or register operand.
- Decomposes an 8-bit shift amount into steps of at most 7 positions.
- Applies one step per clock using an internal single-stage shift datapath.
- Returns the final 8-bit result to the ALU output mux with a START/BUSY/DONE handshake.
- Supports SLL, SRL, SRA and ROR.

Parameters:
MAX_STEP, 7, largest shift applied per cycle (range 1..7; the 3-bit shifter limit)

Ports:
CLK  input  1  system clock, all state updates on rising edge
RESET  input  1  synchronous active-low reset
START  input  1  request strobe; sampled only when ready (state IDLE or DONE)
OPCODE  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROR; latched on accept
DATA1  input  8  operand to shift; latched on accept
AMOUNT  input  8  unsigned shift count 0..255; latched on accept
BUSY  output  1  high while in SHIFT state
DONE  output  1  one-cycle pulse, RESULT valid
RESULT  output  8  shifted value; held until next accept
ZERO  output  1  RESULT==0, registered with RESULT

Behaviour:
- Clock and reset: one clock, CLK. Reset is synchronous and active-low on RESET; the polarity and synchronicity are fixed.
- Reset (RESET==0 at a rising edge):
  - state=IDLE.
  - BUSY=0, DONE=0, RESULT=8'h00, ZERO=1.
  - Internal remaining-count and working register cleared.
  - Reset applied mid-operation aborts the operation with no DONE pulse.
- States: IDLE, SHIFT, DONE.
- Accept:
  - At an edge where the state is IDLE or DONE and START=1, latch OPCODE, DATA1 and AMOUNT into work/op/rem, then go to SHIFT.
  - An accept from the DONE state allows back-to-back operations.
- START while in SHIFT is ignored. It is not queued.
- SHIFT, at each edge:
  - step=min(rem,MAX_STEP); work=shift(work,op,step); rem=rem-step.
  - If the new rem==0, go to DONE and load RESULT/ZERO from the new work value.
- AMOUNT=0: exactly one SHIFT cycle with step 0, so RESULT=DATA1.
- Latency: N=max(1,ceil(AMOUNT/MAX_STEP)) SHIFT cycles. DONE is high in the cycle after the Nth SHIFT edge.
- DONE state lasts one cycle. It returns to IDLE unless START is accepted at that edge.
- Per-step semantics:
  - SLL: zero-fill at LSB.
  - SRL: zero-fill at MSB.
  - SRA: fill with work[7] of the current working value, which equals the original sign.
  - ROR: bits leaving the LSB re-enter at the MSB.
- Net results for any AMOUNT:
  - SLL/SRL with AMOUNT>=8 give 8'h00.
  - SRA with AMOUNT>=8 gives {8{DATA1[7]}}.
  - ROR gives rotation by AMOUNT mod 8.
- BUSY = (state==SHIFT). DONE and BUSY are never both high.
- RESULT and ZERO change only on entry to DONE or on reset.

Optional Feature:
FAST_PATH_EN
- Defined: at accept, rem is normalised before SHIFT begins.
  - ROR: rem=AMOUNT mod 8.
  - SLL/SRL/SRA: rem=min(AMOUNT,8).
  - Latency therefore drops to at most 2 SHIFT cycles; AMOUNT=0 still takes 1 cycle.
  - RESULT is bit-identical to the non-fast path.
- Undefined: rem=AMOUNT and latency follows the full N formula.

Test Plan:
1. Reset: hold RESET=0 for 2 edges mid-SHIFT (SRL 0xFF by 200), then release -> BUSY=0, DONE=0, RESULT=0x00, ZERO=1; no DONE pulse for the aborted op.
2. SLL DATA1=0x01 AMOUNT=3 -> after 1 SHIFT cycle, DONE pulse with RESULT=0x08, ZERO=0; AMOUNT=0 with DATA1=0x5A -> RESULT=0x5A after 1 cycle.
3. SRA DATA1=0x80 AMOUNT=20 -> RESULT=0xFF. Latency 3 SHIFT cycles without FAST_PATH_EN (steps 7,7,6); 2 with it (steps 7,1).
4. ROR DATA1=0x81 AMOUNT=9 -> RESULT=0xC0. Without FAST_PATH_EN the intermediate work value after step 7 is 0x03.
5. SRL DATA1=0xFF AMOUNT=255 -> RESULT=0x00, ZERO=1. Latency 37 cycles without FAST_PATH_EN, 2 with it; START pulses during BUSY are ignored.
6. Back-to-back: assert START with SLL 0x03 by 1 during the DONE cycle of the previous op -> accepted at that edge, next DONE shows RESULT=0x06, no idle cycle between ops.
